axi_rd_slave: RTL

AXI-3 read-channel slave (responder) that serves read bursts from a word-addressed synchronous memory port. It accepts one read address transaction at a time and handles FIXED, INCR and WRAP bursts of 1–16 beats. It returns data beats with the correct `r_id`, `r_resp` and `r_last`. It is the target-side counterpart of the fabric read master and is used to expose FPGA buffers (e.g. ADC sample RAM) to an AXI read initiator.

---
 rtl/axi_rd_slave.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/axi_rd_slave.sv
// AXI-3 read-channel responder serving FIXED/INCR/WRAP bursts of 1-16 beats
// from a word-addressed synchronous memory port (read data one cycle after
// the strobe). One outstanding transaction; each beat takes FETCH, WAIT, DATA.
module axi_rd_slave #(
  parameter int AXI_RD_ID_WIDTH   = 8,
  parameter int AXI_RD_ADDR_WIDTH = 32,
  parameter int AXI_RD_BUS_WIDTH  = 32,
  parameter logic [AXI_RD_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int MEM_WORDS         = 256,
  localparam int MEM_ADDR_WIDTH   = $clog2(MEM_WORDS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [AXI_RD_ID_WIDTH-1:0]   ar_id,
  input  logic [AXI_RD_ADDR_WIDTH-1:0] ar_addr,
  input  logic [3:0]                   ar_len,
  input  logic [2:0]                   ar_size,
  input  logic [1:0]                   ar_burst,
  input  logic [2:0]                   ar_prot,
  input  logic                         ar_valid,
  output logic                         ar_ready,
  output logic [AXI_RD_ID_WIDTH-1:0]   r_id,
  output logic [AXI_RD_BUS_WIDTH-1:0]  r_data,
  output logic [1:0]                   r_resp,
  output logic                         r_last,
  output logic                         r_valid,
  input  logic                         r_ready,
  output logic                         mem_rd,
  output logic [MEM_ADDR_WIDTH-1:0]    mem_addr,
  input  logic [AXI_RD_BUS_WIDTH-1:0]  mem_rdata
);

  localparam int AW         = AXI_RD_ADDR_WIDTH;
  localparam int BUS_BYTES  = AXI_RD_BUS_WIDTH / 8;
  localparam int BUS_LOG2   = $clog2(BUS_BYTES);
  localparam logic [2:0] BUS_LOG2_L = 3'(BUS_LOG2);
  localparam logic [AW-1:0] ONE = AW'(1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DATA} state_t;

  // Address of the beat following 'addr' for the given burst shape.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                              input logic [2:0]    size,
                                              input logic [3:0]    len,
                                              input logic [1:0]    burst);
    logic [AW-1:0] bytes;
    logic [AW-1:0] wsize;
    bytes = ONE << size;
    wsize = AW'({1'b0, len} + 5'd1) << size;
    case (burst)
      2'b01:   next_addr = (addr & ~(bytes - ONE)) + bytes;
      2'b10:   next_addr = (addr & ~(wsize - ONE)) | ((addr + bytes) & (wsize - ONE));
      default: next_addr = addr;
    endcase
  endfunction

  // Shape errors that make every beat of the burst a slave error.
  function automatic logic burst_bad(input logic [2:0] size,
                                     input logic [3:0] len,
                                     input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    burst_bad = (burst == 2'b11) || (size > BUS_LOG2_L) ||
                ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  state_t                       state_q;
  logic                         ar_ready_q;
  logic [AXI_RD_ID_WIDTH-1:0]   r_id_q;
  logic [AXI_RD_BUS_WIDTH-1:0]  r_data_q;
  logic [1:0]                   r_resp_q;
  logic                         r_last_q;
  logic                         r_valid_q;
  logic                         mem_rd_q;
  logic [MEM_ADDR_WIDTH-1:0]    mem_addr_q;
  logic [AW-1:0]                addr_q;
  logic [3:0]                   len_q;
  logic [2:0]                   size_q;
  logic [1:0]                   burst_q;
  logic [3:0]                   cnt_q;
  logic                         burst_err_q;
  logic                         dec_err_q;

  logic [AW-1:0]                fetch_addr_d;
  logic [AW-1:0]                off_d;
  logic [AW-1:0]                word_d;
  logic                         borrow_d;
  logic                         dec_err_d;
  logic                         burst_err_d;
  logic [MEM_ADDR_WIDTH-1:0]    mem_addr_d;

  // Protection bits carry no meaning for this target.
  logic unused_prot;
  assign unused_prot = ^ar_prot;

  // Address and decode of the beat about to enter FETCH (first beat from AR, later beats advanced).
  always_comb begin
    fetch_addr_d       = (state_q == S_IDLE) ? ar_addr
                                             : next_addr(addr_q, size_q, len_q, burst_q);
    {borrow_d, off_d}  = {1'b0, fetch_addr_d} - {1'b0, BASE_ADDR};
    word_d             = off_d >> BUS_LOG2;
    dec_err_d          = borrow_d || (word_d >= AW'(MEM_WORDS));
    burst_err_d        = (state_q == S_IDLE) ? burst_bad(ar_size, ar_len, ar_burst)
                                             : burst_err_q;
    mem_addr_d         = word_d[MEM_ADDR_WIDTH-1:0];
  end

  // Transaction FSM with registered AR/R/memory outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ar_ready_q  <= 1'b0;
      r_id_q      <= '0;
      r_data_q    <= '0;
      r_resp_q    <= RESP_OKAY;
      r_last_q    <= 1'b0;
      r_valid_q   <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      burst_err_q <= 1'b0;
      dec_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ar_ready_q <= 1'b1;
          if (ar_valid && ar_ready_q) begin
            ar_ready_q  <= 1'b0;
            r_id_q      <= ar_id;
            addr_q      <= ar_addr;
            len_q       <= ar_len;
            size_q      <= ar_size;
            burst_q     <= ar_burst;
            cnt_q       <= '0;
            burst_err_q <= burst_err_d;
            dec_err_q   <= dec_err_d;
            mem_rd_q    <= !burst_err_d && !dec_err_d;
            if (!burst_err_d && !dec_err_d) mem_addr_q <= mem_addr_d;
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: begin
          mem_rd_q <= 1'b0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          r_data_q  <= (!burst_err_q && !dec_err_q) ? mem_rdata : '0;
          r_resp_q  <= burst_err_q ? RESP_SLVERR : (dec_err_q ? RESP_DECERR : RESP_OKAY);
          r_last_q  <= (cnt_q == len_q);
          r_valid_q <= 1'b1;
          state_q   <= S_DATA;
        end
        S_DATA: begin
          if (r_ready) begin
            r_valid_q <= 1'b0;
            if (r_last_q) begin
              ar_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              cnt_q     <= cnt_q + 4'd1;
              addr_q    <= fetch_addr_d;
              dec_err_q <= dec_err_d;
              mem_rd_q  <= !burst_err_q && !dec_err_d;
              if (!burst_err_q && !dec_err_d) mem_addr_q <= mem_addr_d;
              state_q   <= S_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ar_ready = ar_ready_q;
  assign r_id     = r_id_q;
  assign r_data   = r_data_q;
  assign r_resp   = r_resp_q;
  assign r_last   = r_last_q;
  assign r_valid  = r_valid_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

endmodule
